div_share_ctrl: RTL

- Sequencing and arbitration controller for the shared 8-bit lookup-table fast divider.
- Accepts divide requests from N_REQ clients using valid/ready handshakes and picks one with round-robin arbitration.
- Drives the divider's xin/yin/enbl inputs and holds operands stable for the divider's fixed latency.
- Captures the 16-bit result and returns it, tagged with the requester ID, on a single response channel with backpressure.

---
 rtl/div_ctrl_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/div_share_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider-sharing controller and its arbiter.
package div_ctrl_pkg;

  localparam int OPND_W = 8;
  localparam int RES_W  = 16;
  localparam int CNT_W  = 4;

  localparam logic [RES_W-1:0] DZ_RESULT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Round-robin successor of idx in a ring of n clients.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping to the lowest asserted request below it.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  logic [ID_W-1:0] w_hi_idx;
  logic [ID_W-1:0] w_lo_idx;
  logic            w_hi_found;
  logic            w_lo_found;

  // Descending scan so the last hit in each class is the lowest index.
  always_comb begin
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_lo_idx   = ID_W'(i);
        w_lo_found = 1'b1;
        if (ID_W'(i) >= i_ptr) begin
          w_hi_idx   = ID_W'(i);
          w_hi_found = 1'b1;
        end
      end
    end
  end

  assign o_any = w_lo_found;
  assign o_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  assign o_gnt = w_lo_found ? (N_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/div_share_ctrl.sv
// Arbitrates N_REQ clients onto one fixed-latency divider and returns tagged
// results. Optional zero-divisor bypass: define DIV_SHARE_CTRL_DZ_CHECK_EN.
module div_share_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DIV_LAT = 2,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [OPND_W*N_REQ-1:0]  req_x,
  input  logic [OPND_W*N_REQ-1:0]  req_y,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [RES_W-1:0]         rsp_data,
  output logic                     rsp_dz,
  output logic [OPND_W-1:0]        div_xin,
  output logic [OPND_W-1:0]        div_yin,
  output logic                     div_enbl,
  input  logic [RES_W-1:0]         div_xyout,
  output logic [1:0]               dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and rsp_* hold until accepted.

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_ptr;
  logic [CNT_W-1:0]    r_cnt;
  logic [OPND_W-1:0]   r_xin;
  logic [OPND_W-1:0]   r_yin;
  logic                r_enbl;
  logic [ID_W-1:0]     r_id;
  logic [RES_W-1:0]    r_data;
  logic                r_dz;
  logic                r_rsp_valid;

  logic [N_REQ-1:0]    w_gnt;
  logic [ID_W-1:0]     w_gidx;
  logic                w_any;
  logic [OPND_W-1:0]   w_sel_x;
  logic [OPND_W-1:0]   w_sel_y;
  logic                w_zero_div;
  logic                w_accept;
  logic                w_done;
  logic                w_hs;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gidx),
    .o_any (w_any)
  );

  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gidx == ID_W'(i)) begin
        w_sel_x = req_x[i*OPND_W +: OPND_W];
        w_sel_y = req_y[i*OPND_W +: OPND_W];
      end
    end
  end

`ifdef DIV_SHARE_CTRL_DZ_CHECK_EN
  assign w_zero_div = (w_sel_y == '0);
`else
  assign w_zero_div = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_accept    = 1'b1;
          w_state_nxt = w_zero_div ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_hs        = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_ptr <= ID_W'(wrap_inc(int'(w_gidx), N_REQ));
      end
    end
  end

  // Operands are captured only on the accept edge and held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xin  <= '0;
      r_yin  <= '0;
      r_enbl <= 1'b0;
      r_id   <= '0;
    end else if (w_accept) begin
      r_xin  <= w_sel_x;
      r_yin  <= w_sel_y;
      r_enbl <= ~w_zero_div;
      r_id   <= w_gidx;
    end else if (w_hs) begin
      r_enbl <= 1'b0;
    end
  end

  // Counter runs DIV_LAT down to 0; the capture happens on the edge after 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= CNT_W'(DIV_LAT);
    end else if (r_state == ST_WAIT && !w_done) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data      <= '0;
      r_dz        <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else if (w_accept) begin
      r_dz <= w_zero_div;
      if (w_zero_div) begin
        r_data      <= DZ_RESULT;
        r_rsp_valid <= 1'b1;
      end
    end else if (w_done) begin
      r_data      <= div_xyout;
      r_rsp_valid <= 1'b1;
    end else if (w_hs) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign req_ready = (r_state == ST_IDLE) ? w_gnt : '0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
  assign rsp_dz    = r_dz;
  assign div_xin   = r_xin;
  assign div_yin   = r_yin;
  assign div_enbl  = r_enbl;
  assign dbg_state = r_state;

endmodule
